// File: rtl/accum_write_sequencer.sv
// Generates accumulator-table write strobes, row indices and tile (m,n) positions for one
// tiled matrix multiply, counting rows as they leave the systolic array (n inner, m outer).
module accum_write_sequencer #(
   parameter int MAX_OUT_ROWS  = 128,
   parameter int MAX_OUT_COLS  = 128,
   parameter int SYS_ARR_ROWS  = 16,
   parameter int SYS_ARR_COLS  = 16,
   parameter int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS,
   parameter int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS,
   parameter int CW            = $clog2(SYS_ARR_ROWS),
   parameter int MW            = $clog2(NUM_SUBMATS_M),
   parameter int NW            = $clog2(NUM_SUBMATS_N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [MW-1:0] m_last,
   input  logic [NW-1:0] n_last,
   input  logic          row_valid,
   input  logic          abort,
   output logic          wr_en,
   output logic [CW-1:0] sys_arr_count,
   output logic [MW-1:0] submat_m,
   output logic [NW-1:0] submat_n,
   output logic          busy,
   output logic          done,
   output logic          overrun
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(SYS_ARR_ROWS - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [MW-1:0] r_m;
   logic [NW-1:0] r_n;
   logic [MW-1:0] r_m_last;
   logic [NW-1:0] r_n_last;

   logic w_tile_end;
   logic w_row_end;
   logic w_final;

   assign w_tile_end = (r_cnt == LAST_CNT);
   assign w_row_end  = w_tile_end && (r_n == r_n_last);
   assign w_final    = w_row_end && (r_m == r_m_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_m           <= '0;
         r_n           <= '0;
         r_m_last      <= '0;
         r_n_last      <= '0;
         wr_en         <= 1'b0;
         sys_arr_count <= '0;
         submat_m      <= '0;
         submat_n      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (row_valid) overrun <= 1'b1;
               // An accepted start clears overrun even if a stray row arrives in the same cycle.
               if (start && !abort) begin
                  r_state  <= RUN;
                  busy     <= 1'b1;
                  r_cnt    <= '0;
                  r_m      <= '0;
                  r_n      <= '0;
                  r_m_last <= m_last;
                  r_n_last <= n_last;
                  overrun  <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end else if (row_valid) begin
                  wr_en         <= 1'b1;
                  sys_arr_count <= r_cnt;
                  submat_m      <= r_m;
                  submat_n      <= r_n;
                  if (w_final) begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (w_tile_end) begin
                        r_n <= w_row_end ? '0 : r_n + 1'b1;
                        if (w_row_end) r_m <= r_m + 1'b1;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accum_write_sequencer.sv
// Directed and randomized checks of accum_write_sequencer against a write-index reference model.
module tb_accum_write_sequencer;

   localparam int ROWS = 16;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] m_last;
   logic [2:0] n_last;
   logic       row_valid;
   logic       abort;
   logic       wr_en;
   logic [3:0] sys_arr_count;
   logic [2:0] submat_m;
   logic [2:0] submat_n;
   logic       busy;
   logic       done;
   logic       overrun;

   accum_write_sequencer dut (
      .clk          (clk),
      .reset        (rst_n),
      .start        (start),
      .m_last       (m_last),
      .n_last       (n_last),
      .row_valid    (row_valid),
      .abort        (abort),
      .wr_en        (wr_en),
      .sys_arr_count(sys_arr_count),
      .submat_m     (submat_m),
      .submat_n     (submat_n),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a job is a linear write index k; (cnt,m,n) are derived arithmetically.
   bit m_busy;
   bit m_ov;
   int m_k;
   int m_ml;
   int m_nl;
   int e_wr, e_cnt, e_m, e_n, e_done;
   int writes_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".wr_en"},   32'(wr_en),         32'(e_wr));
      check({tag, ".count"},   32'(sys_arr_count), 32'(e_cnt));
      check({tag, ".m"},       32'(submat_m),      32'(e_m));
      check({tag, ".n"},       32'(submat_n),      32'(e_n));
      check({tag, ".busy"},    32'(busy),          32'(m_busy));
      check({tag, ".done"},    32'(done),          32'(e_done));
      check({tag, ".overrun"}, 32'(overrun),       32'(m_ov));
   endtask

   task automatic model_reset();
      m_busy = 0; m_ov = 0; m_k = 0; m_ml = 0; m_nl = 0;
      e_wr = 0; e_cnt = 0; e_m = 0; e_n = 0; e_done = 0;
   endtask

   // Drive one cycle of inputs, predict the registered result, clock, then compare.
   task automatic cycle(input string tag, input bit s, input bit rv, input bit ab);
      int tile;
      start = s; row_valid = rv; abort = ab;
      e_wr = 0; e_done = 0;
      if (!m_busy) begin
         if (rv) m_ov = 1;
         if (s && !ab) begin
            m_busy = 1; m_k = 0; m_ov = 0;
            m_ml = int'(m_last); m_nl = int'(n_last);
         end
      end else if (ab) begin
         m_busy = 0;
      end else if (rv) begin
         e_wr  = 1;
         e_cnt = m_k % ROWS;
         tile  = m_k / ROWS;
         e_n   = tile % (m_nl + 1);
         e_m   = tile / (m_nl + 1);
         m_k++;
         if (m_k == ROWS * (m_ml + 1) * (m_nl + 1)) begin
            e_done = 1;
            m_busy = 0;
         end
      end
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) writes_seen++;
      check_all(tag);
      start = 0; row_valid = 0; abort = 0;
   endtask

   task automatic job_start(input string tag, input int ml, input int nl);
      m_last = 3'(ml); n_last = 3'(nl);
      cycle(tag, 1, 0, 0);
   endtask

   initial begin
      rst_n = 0; start = 0; row_valid = 0; abort = 0; m_last = 0; n_last = 0;
      model_reset();
      writes_seen = 0;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      check_all("post_reset");

      // 1: single tile, back-to-back rows
      job_start("t1_start", 0, 0);
      writes_seen = 0;
      for (int i = 0; i < ROWS; i++) cycle("t1_row", 0, 1, 0);
      check("t1_writes", 32'(writes_seen), 32'd16);
      cycle("t1_idle", 0, 0, 0);

      // 2: 2x3 tiles, tile order n inner
      job_start("t2_start", 1, 2);
      writes_seen = 0;
      for (int i = 0; i < 96; i++) cycle("t2_row", 0, 1, 0);
      check("t2_writes", 32'(writes_seen), 32'd96);
      cycle("t2_after", 0, 1, 0);

      // 3: alternating row_valid with gaps
      job_start("t3_start", 0, 1);
      writes_seen = 0;
      for (int i = 0; i < 64; i++) cycle("t3_alt", 0, (i % 2) == 0, 0);
      check("t3_writes", 32'(writes_seen), 32'd32);

      // 4: abort mid-job, then restart from (0,0,0)
      job_start("t4_start", 1, 1);
      for (int i = 0; i < 20; i++) cycle("t4_row", 0, 1, 0);
      cycle("t4_abort", 0, 1, 1);
      cycle("t4_idle", 0, 0, 1);
      cycle("t4_abort_start", 1, 0, 1);
      job_start("t4_restart", 1, 1);
      cycle("t4_first", 0, 1, 0);
      check("t4_first_cnt", 32'(sys_arr_count), 32'd0);
      for (int i = 0; i < 63; i++) cycle("t4_rest", 0, 1, 0);

      // 5: asynchronous reset mid-job
      job_start("t5_start", 2, 2);
      for (int i = 0; i < 37; i++) cycle("t5_row", 0, 1, 0);
      row_valid = 1;
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_all("t5_async");
      @(negedge clk);
      row_valid = 0;
      rst_n = 1;
      writes_seen = 0;
      for (int i = 0; i < 4; i++) cycle("t5_idle", 0, 0, 0);
      check("t5_writes", 32'(writes_seen), 32'd0);

      // 6: overrun in IDLE, sticky until start; start during RUN ignored
      cycle("t6_stray", 0, 1, 0);
      cycle("t6_sticky", 0, 0, 0);
      cycle("t6_sticky2", 0, 0, 0);
      job_start("t6_start", 0, 1);
      writes_seen = 0;
      for (int i = 0; i < 32; i++) cycle("t6_row", (i % 5) == 2, 1, 0);
      check("t6_writes", 32'(writes_seen), 32'd32);

      // Randomized jobs: random shape, gaps and stray starts
      for (int j = 0; j < 6; j++) begin
         int ml, nl, total, guard;
         ml = $urandom_range(0, 3);
         nl = $urandom_range(0, 3);
         total = ROWS * (ml + 1) * (nl + 1);
         for (int i = 0; i < $urandom_range(0, 2); i++)
            cycle("rnd_pre", 0, $urandom_range(0, 1) == 1, 0);
         job_start("rnd_start", ml, nl);
         writes_seen = 0;
         guard = 0;
         while (m_busy && guard < 2000) begin
            cycle("rnd_run", $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 0);
            guard++;
         end
         check("rnd_writes", 32'(writes_seen), 32'(total));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
